// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - microcoded datapath control sequencer
// Loadable microcode table drives the control word; branches on mayor/bandera.
module ucode_sequencer #(
  parameter int CW_W      = 15,
  parameter int AW        = 4,
  parameter int MAX_STEPS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mayor,
  input  logic                  bandera,
  input  logic                  ld_en,
  input  logic [AW-1:0]         ld_addr,
  input  logic [3+AW+CW_W-1:0]  ld_data,
  output logic                  ld_ack,
  output logic [CW_W-1:0]       o_signal,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           steps
);

  localparam int DW    = 3 + AW + CW_W;
  localparam int DEPTH = 1 << AW;

  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_JMP    = 3'b001;
  localparam logic [2:0] OP_BR_MAY = 3'b010;
  localparam logic [2:0] OP_BR_BAN = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [15:0]     steps_q, steps_d;
  logic            ld_ack_q, ld_ack_d;
  logic            mem_we;
  logic [DW-1:0]   mem_q [DEPTH];

  logic [DW-1:0]   word;
  logic [2:0]      op;
  logic [AW-1:0]   target;
  logic [AW-1:0]   pc_inc;
  logic [16:0]     steps_inc;
  logic [15:0]     steps_sat;
  logic            wd_hit;

  assign word      = mem_q[pc_q];
  assign op        = word[DW-1 -: 3];
  assign target    = word[CW_W +: AW];
  assign pc_inc    = pc_q + AW'(1);
  assign steps_inc = {1'b0, steps_q} + 17'd1;
  assign steps_sat = (steps_q == 16'hFFFF) ? steps_q : steps_inc[15:0];
  // Watchdog fires on the edge that would execute the MAX_STEPS-th non-halt word.
  assign wd_hit    = (MAX_STEPS != 0) && (steps_inc == 17'(MAX_STEPS));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    steps_d  = steps_q;
    ld_ack_d = 1'b0;
    mem_we   = 1'b0;
    o_signal = '0;
    case (state_q)
      S_RUN: begin
        o_signal = word[CW_W-1:0];
        steps_d  = steps_sat;
        case (op)
          OP_NEXT:   pc_d = pc_inc;
          OP_JMP:    pc_d = target;
          OP_BR_MAY: pc_d = mayor ? target : pc_inc;
          OP_BR_BAN: pc_d = bandera ? target : pc_inc;
          default:   state_d = S_DONE;
        endcase
        if (!op[2] && wd_hit) begin
          state_d = S_ERR;
        end
      end
      default: begin
        // Loading takes priority over start in the quiescent states.
        if (ld_en) begin
          mem_we   = 1'b1;
          ld_ack_d = 1'b1;
        end else if (start) begin
          pc_d    = '0;
          steps_d = '0;
          state_d = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      steps_q  <= '0;
      ld_ack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      steps_q  <= steps_d;
      ld_ack_q <= ld_ack_d;
    end
  end

  // Microcode storage survives reset.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_ERR);
  assign steps  = steps_q;
  assign ld_ack = ld_ack_q;

endmodule
